crypto_bist_sequencer: RTL and testbench

- On-chip, parametrised replacement for the bench-driven reset/start/wait-for-`cpu_done` flow.
- Walks NUM_VEC plaintext/expected-ciphertext pairs from an external vector ROM through the crypto core using a start/done handshake, and compares each result.
- Accumulates pass/fail status, a fail count and the first failing index, with a per-vector timeout watchdog.
- Sits between the board top level (KEY/SW/LEDR/HEX) and the accelerator core.

---
 rtl/crypto_pkg.sv | 21 ++
 rtl/crypto_bist_sequencer_if.sv | 25 ++
 rtl/bist_watchdog.sv | 31 +++
 rtl/crypto_bist_sequencer.sv | 124 ++++++++++++
 tb/tb_crypto_bist_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crypto_pkg.sv
// Shared constants for the crypto BIST slice: FSM encoding and parameter defaults.
// No logic; consumed by the sequencer, its watchdog and the core monitors.
// Helper addr_w gives the ROM address width for a vector count (minimum 1 bit).
package crypto_pkg;

    localparam int DATA_W_DEF  = 128;
    localparam int TIMEOUT_DEF = 4096;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_CHECK = 3'd5;
    localparam logic [2:0] ST_FIN   = 3'd6;

    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/crypto_bist_sequencer_if.sv
// Vector ROM read port plus the start/done handshake to the crypto core.
// ROM data is valid one cycle after vec_addr; dut_result is valid with dut_done.
// No backpressure: the core answers with a single done pulse per start pulse.
interface crypto_bist_sequencer_if #(
    parameter int DATA_W = 128,
    parameter int AW     = 3
);
    logic [AW-1:0]     vec_addr;
    logic [DATA_W-1:0] vec_plain;
    logic [DATA_W-1:0] vec_expect;
    logic              dut_start;
    logic [DATA_W-1:0] dut_data;
    logic              dut_done;
    logic [DATA_W-1:0] dut_result;

    modport master (
        output vec_addr, dut_start, dut_data,
        input  vec_plain, vec_expect, dut_done, dut_result
    );

    modport slave (
        input  vec_addr, dut_start, dut_data,
        output vec_plain, vec_expect, dut_done, dut_result
    );
endinterface

// File: rtl/bist_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear.
// expired is combinational and high on the LIMIT-th enabled cycle itself.
// No backpressure; the counter holds at LIMIT instead of wrapping.
module bist_watchdog
    import crypto_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // count enabled cycles, saturating so a stuck enable never wraps to zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of earlier enabled cycles, so LIMIT-1 marks the last allowed one
    assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/crypto_bist_sequencer.sv
// Built-in self test: walks NUM_VEC ROM vectors through the core and tallies mismatches/timeouts.
// Latency: 4 cycles + core latency per vector (timeout caps the wait), plus 1 closing cycle per run.
// No backpressure; start while busy is dropped, dut_done outside WAIT is ignored.
module crypto_bist_sequencer
    import crypto_pkg::*;
#(
    parameter int  DATA_W       = DATA_W_DEF,
    parameter int  NUM_VEC      = 8,
    parameter int  TIMEOUT      = TIMEOUT_DEF,
    parameter int  STOP_ON_FAIL = 0,
    localparam int AW           = addr_w(NUM_VEC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    crypto_bist_sequencer_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [AW:0]             fail_cnt,
    output logic [AW-1:0]           first_fail,
    output logic                    timeout_seen
);
    logic [2:0]        state;
    logic [AW-1:0]     addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] expect_q;
    logic [DATA_W-1:0] result_q;
    logic              timed_out;
    logic              wd_expired;
    logic              vec_fail;
    logic              last_vec;

    // watchdog only advances on WAIT cycles without done, so a done on the final cycle still wins
    bist_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ST_LOAD),
        .en      ((state == ST_WAIT) && !bus.dut_done),
        .expired (wd_expired)
    );

    assign vec_fail = timed_out || (result_q != expect_q);
    assign last_vec = (addr_q == AW'(NUM_VEC - 1));

    assign bus.vec_addr  = addr_q;
    assign bus.dut_data  = data_q;
    assign bus.dut_start = (state == ST_ISSUE);

    // run sequencer: fetch, issue, wait, compare, then advance or finish
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            expect_q     <= '0;
            result_q     <= '0;
            timed_out    <= 1'b0;
            fail_cnt     <= '0;
            first_fail   <= '0;
            timeout_seen <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q       <= '0;
                        fail_cnt     <= '0;
                        first_fail   <= '0;
                        timeout_seen <= 1'b0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    data_q    <= bus.vec_plain;
                    expect_q  <= bus.vec_expect;
                    timed_out <= 1'b0;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.dut_done) begin
                        result_q <= bus.dut_result;
                        state    <= ST_CHECK;
                    end else if (wd_expired) begin
                        timed_out    <= 1'b1;
                        timeout_seen <= 1'b1;
                        state        <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (vec_fail) begin
                        if (fail_cnt == '0) begin
                            first_fail <= addr_q;
                        end
                        if (fail_cnt != (AW + 1)'(NUM_VEC)) begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
                    end
                    if (last_vec || ((STOP_ON_FAIL != 0) && vec_fail)) begin
                        state <= ST_FIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        state  <= ST_FETCH;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (fail_cnt == '0);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_bist_sequencer.sv
// Bench for crypto_bist_sequencer: two instances (STOP_ON_FAIL 0 and 1) share stimulus.
// A core model answers each start after a configured latency (0 = never answers).
// Expected run summaries and issued plaintexts are queued at stimulus time and checked by monitors.
module tb_crypto_bist_sequencer;
    localparam int NV  = 4;
    localparam int TMO = 16;
    localparam int DW  = 128;
    localparam int AW  = 2;

    typedef struct {
        int fail_cnt;
        int first_fail;
        int tmo;
        int pass;
        int issues;
        int cycles;
    } summ_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic spur_done;

    always #5 clk = ~clk;

    logic [DW-1:0] rom_plain [NV];
    logic [DW-1:0] rom_exp   [NV];
    int            cfg_lat   [NV];
    bit            cfg_bad   [NV];
    logic [DW-1:0] cfg_mask;

    summ_t         exp_q   [2][$];
    logic [DW-1:0] plain_q [2][$];

    logic          busy_a   [2];
    logic          done_a   [2];
    logic          pass_a   [2];
    logic          tseen_a  [2];
    logic          dstart_a [2];
    logic [AW:0]   fcnt_a   [2];
    logic [AW-1:0] ffail_a  [2];
    logic [AW-1:0] vaddr_a  [2];
    logic [DW-1:0] ddata_a  [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected at this point", name);
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        crypto_bist_sequencer_if #(.DATA_W(DW), .AW(AW)) ifc ();

        logic          busy_o, done_o, pass_o, tseen_o;
        logic [AW:0]   fcnt_o;
        logic [AW-1:0] ffail_o;
        logic          mdone;
        logic [DW-1:0] mres;

        crypto_bist_sequencer #(
            .DATA_W(DW), .NUM_VEC(NV), .TIMEOUT(TMO), .STOP_ON_FAIL(g)
        ) dut (
            .clk(clk), .rst(rst), .start(start), .bus(ifc),
            .busy(busy_o), .done(done_o), .pass(pass_o),
            .fail_cnt(fcnt_o), .first_fail(ffail_o), .timeout_seen(tseen_o)
        );

        assign ifc.dut_done   = mdone | spur_done;
        assign ifc.dut_result = mres;
        assign busy_a[g]   = busy_o;
        assign done_a[g]   = done_o;
        assign pass_a[g]   = pass_o;
        assign tseen_a[g]  = tseen_o;
        assign fcnt_a[g]   = fcnt_o;
        assign ffail_a[g]  = ffail_o;
        assign vaddr_a[g]  = ifc.vec_addr;
        assign ddata_a[g]  = ifc.dut_data;
        assign dstart_a[g] = ifc.dut_start;

        // synchronous vector ROM with one cycle of read latency
        always @(posedge clk) begin
            ifc.vec_plain  <= rom_plain[ifc.vec_addr];
            ifc.vec_expect <= rom_exp[ifc.vec_addr];
        end

        // core model: answer in the lat-th cycle after the start pulse
        initial begin : core
            int idx;
            int lat;
            logic [DW-1:0] r;
            mdone = 1'b0;
            mres  = '0;
            forever begin
                @(negedge clk);
                if (ifc.dut_start === 1'b1) begin
                    idx = -1;
                    for (int i = 0; i < NV; i++)
                        if (rom_plain[i] == ifc.dut_data) idx = i;
                    if (idx >= 0 && cfg_lat[idx] != 0) begin
                        lat = cfg_lat[idx];
                        r   = rom_exp[idx] ^ (cfg_bad[idx] ? cfg_mask : {DW{1'b0}});
                        repeat (lat) @(posedge clk);
                        #1;
                        mdone = 1'b1;
                        mres  = r;
                        @(posedge clk);
                        #1;
                        mdone = 1'b0;
                        mres  = ~r;
                    end
                end
            end
        end

        // monitor: check each issued plaintext and each finished run summary
        initial begin : mon
            logic prev_busy, prev_done;
            int cyc, issues;
            summ_t e;
            prev_busy = 1'b0;
            prev_done = 1'b0;
            cyc = 0;
            issues = 0;
            forever begin
                @(negedge clk);
                cyc++;
                if (busy_o === 1'b1 && !prev_busy) begin
                    cyc = 0;
                    issues = 0;
                end
                if (ifc.dut_start === 1'b1) begin
                    issues++;
                    if (plain_q[g].size() == 0) flag($sformatf("issue_extra%0d", g));
                    else check_vec($sformatf("issue_data%0d", g), ifc.dut_data, plain_q[g].pop_front());
                end
                if (done_o === 1'b1 && !prev_done) begin
                    if (exp_q[g].size() == 0) begin
                        flag($sformatf("done_extra%0d", g));
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("fail_cnt%0d", g), 64'(fcnt_o), 64'(e.fail_cnt));
                        check($sformatf("first_fail%0d", g), 64'(ffail_o), 64'(e.first_fail));
                        check($sformatf("timeout_seen%0d", g), 64'(tseen_o), 64'(e.tmo));
                        check($sformatf("pass%0d", g), 64'(pass_o), 64'(e.pass));
                        check($sformatf("issues%0d", g), 64'(issues), 64'(e.issues));
                        check($sformatf("cycles%0d", g), 64'(cyc), 64'(e.cycles));
                        check($sformatf("busy_end%0d", g), 64'(busy_o), 64'd0);
                    end
                end
                prev_busy = (busy_o === 1'b1);
                prev_done = (done_o === 1'b1);
            end
        end
    end

    // reference: per vector, fail if never answered or corrupted; a silent core costs TMO wait cycles
    task automatic expect_run(input int g);
        summ_t s;
        bit f, to;
        s = '{default: 0};
        s.cycles = 1;
        for (int i = 0; i < NV; i++) begin
            to = (cfg_lat[i] == 0);
            f  = to || cfg_bad[i];
            plain_q[g].push_back(rom_plain[i]);
            s.issues++;
            s.cycles += 4 + (to ? TMO : cfg_lat[i]);
            if (f) begin
                if (s.fail_cnt == 0) s.first_fail = i;
                s.fail_cnt++;
            end
            if (to) s.tmo = 1;
            if (f && g == 1) break;
        end
        s.pass = (s.fail_cnt == 0) ? 1 : 0;
        exp_q[g].push_back(s);
    endtask

    task automatic fill_rom();
        for (int i = 0; i < NV; i++) begin
            rom_plain[i] = {$urandom, $urandom, $urandom, $urandom};
            rom_plain[i][1:0] = i[1:0];
            rom_exp[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic set_cfg(input int lat);
        for (int i = 0; i < NV; i++) begin
            cfg_lat[i] = lat;
            cfg_bad[i] = 1'b0;
        end
    endtask

    task automatic check_idle(input string t);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_busy%0d", t, g), 64'(busy_a[g]), 64'd0);
            check($sformatf("%s_done%0d", t, g), 64'(done_a[g]), 64'd0);
            check($sformatf("%s_pass%0d", t, g), 64'(pass_a[g]), 64'd0);
            check($sformatf("%s_fcnt%0d", t, g), 64'(fcnt_a[g]), 64'd0);
            check($sformatf("%s_ffail%0d", t, g), 64'(ffail_a[g]), 64'd0);
            check($sformatf("%s_tseen%0d", t, g), 64'(tseen_a[g]), 64'd0);
            check($sformatf("%s_addr%0d", t, g), 64'(vaddr_a[g]), 64'd0);
            check($sformatf("%s_dstart%0d", t, g), 64'(dstart_a[g]), 64'd0);
            check_vec($sformatf("%s_ddata%0d", t, g), ddata_a[g], {DW{1'b0}});
        end
    endtask

    task automatic run(input bit extra, input bit spur);
        int budget;
        expect_run(0);
        expect_run(1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        budget = 0;
        while (!(done_a[0] === 1'b1 && done_a[1] === 1'b1) && budget < 3000) begin
            if (extra && budget >= 1 && budget <= 3 && busy_a[0] && busy_a[1]) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            budget++;
        end
        if (budget >= 3000) flag("run_budget");
        repeat (2) @(posedge clk);
        #1;
        if (spur) begin
            spur_done = 1'b1;
            @(posedge clk);
            #1 spur_done = 1'b0;
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                check($sformatf("spur_done%0d", g), 64'(done_a[g]), 64'd1);
                check($sformatf("spur_busy%0d", g), 64'(busy_a[g]), 64'd0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "stopped");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        spur_done = 1'b0;
        cfg_mask = {{(DW-1){1'b0}}, 1'b1};
        set_cfg(10);
        fill_rom();
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // clean run, core answers in 10 cycles
        run(1'b0, 1'b0);

        // bit 0 corrupted on vector 2
        cfg_bad[2] = 1'b1;
        run(1'b0, 1'b0);

        // vector 1 never answered, the rest answer on the last allowed cycle
        set_cfg(TMO);
        cfg_lat[1] = 0;
        run(1'b0, 1'b0);

        // extra start pulses while busy, then a spurious done while idle
        set_cfg(5);
        run(1'b1, 1'b1);

        // reset while vector 2 is waiting; its late done lands in IDLE
        set_cfg(10);
        cfg_lat[2] = 12;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 3; i++) plain_q[g].push_back(rom_plain[i]);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check($sformatf("pre_rst_addr%0d", g), 64'(vaddr_a[g]), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("midrst");
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_idle("late_done");
        for (int g = 0; g < 2; g++) check($sformatf("midrst_left%0d", g), 64'(plain_q[g].size()), 64'd0);
        run(1'b0, 1'b0);

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            fill_rom();
            cfg_mask = {$urandom, $urandom, $urandom, $urandom} | {{(DW-1){1'b0}}, 1'b1};
            for (int i = 0; i < NV; i++) begin
                cfg_lat[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TMO));
                cfg_bad[i] = ($urandom_range(0, 3) == 0);
            end
            run(r[0], (r % 3) == 0);
        end

        for (int g = 0; g < 2; g++) begin
            check($sformatf("exp_left%0d", g), 64'(exp_q[g].size()), 64'd0);
            check($sformatf("plain_left%0d", g), 64'(plain_q[g].size()), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
